// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of one single-port synchronous memory.
// Optional MEM_ARBITER_RR_EN selects round-robin contention; default is fixed data-port priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  // instruction fetch port
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  // memory side
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } port_t;

  rsp_t              r_rsp;
  port_t             r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_d_write;
  logic              w_unused;

  // Grants are gated by reset so nothing can transfer in a cycle where reset is sampled.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (RESET) begin
      if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
        if (r_last_gnt == GNT_I) begin
          w_d_gnt = 1'b1;
        end else begin
          w_i_gnt = 1'b1;
        end
`else
        w_d_gnt = 1'b1;
`endif
      end else begin
        w_i_gnt = i_req;
        w_d_gnt = d_req;
      end
    end
  end

  assign w_d_write = w_d_gnt && d_we;

  assign i_gnt  = w_i_gnt;
  assign d_gnt  = w_d_gnt;
  assign mem_en = w_i_gnt || w_d_gnt;
  assign mem_we = w_d_write ? d_wmask : '0;

  // Idle cycles replay the last address/data so the memory bus does not toggle.
  always_comb begin
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    if (!RESET) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      if (w_d_gnt) begin
        mem_addr = d_addr[ADDR_W+1:2];
      end else if (w_i_gnt) begin
        mem_addr = i_addr[ADDR_W+1:2];
      end
      if (w_d_write) begin
        mem_wdata = d_wdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_rsp      <= RSP_NONE;
      r_last_gnt <= GNT_I;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      if (w_d_gnt) begin
        r_last_gnt <= GNT_D;
        r_rsp      <= d_we ? RSP_NONE : RSP_D;
      end else if (w_i_gnt) begin
        r_last_gnt <= GNT_I;
        r_rsp      <= RSP_I;
      end else begin
        r_rsp <= RSP_NONE;
      end
    end
  end

  assign i_rvalid = (r_rsp == RSP_I);
  assign d_rvalid = (r_rsp == RSP_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  // Byte-offset and wrap bits of the byte addresses are intentionally ignored.
  assign w_unused = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[1:0], d_addr[31:ADDR_W+2]};

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL be the word-address width of the shared memory (256 words).
REQ-002 Port CLK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 Port RESET  input  1  SHALL be the reset, synchronous and active-low (asserted when 0, sampled on the rising CLK edge).
REQ-004 Ports i_req in 1, i_addr in 32 (byte address) SHALL form the instruction-fetch request; i_gnt out 1, i_rdata out 32, i_rvalid out 1 SHALL form its response.
REQ-005 Ports d_req in 1, d_we in 1, d_wmask in 4, d_addr in 32, d_wdata in 32 SHALL form the load/store request; d_gnt out 1, d_rdata out 32, d_rvalid out 1 SHALL form its response.
REQ-006 Ports mem_en out 1, mem_we out 4 (byte enables), mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32 SHALL drive one single-port synchronous memory (read data valid the cycle after mem_en).

Function
REQ-007 A transfer SHALL occur on a port in the cycle its req and gnt are both 1; requester holds req/addr/data stable until then.
REQ-008 At most one of i_gnt, d_gnt SHALL be 1 per cycle; gnt is combinational from req and arbiter state, never 1 without its req.
REQ-009 On a transfer mem_en=1, mem_addr=addr[ADDR_W+1:2]; addr bits [1:0] and above ADDR_W+1 ignored (addresses wrap modulo 4*2^ADDR_W).
REQ-010 Data write transfer (d_we=1): mem_we=d_wmask, mem_wdata=d_wdata; no d_rvalid is produced; d_wmask=0 performs no write but still completes.
REQ-011 Read transfer (instruction, or data with d_we=0): mem_we=0; exactly one cycle later the owner's rvalid=1 and rdata=mem_rdata.
REQ-012 Response owner SHALL be held in a one-entry register (states RSP_NONE, RSP_I, RSP_D); back-to-back transfers every cycle SHALL be supported with no bubble.
REQ-013 i_rdata/d_rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-014 Without contention the sole requester SHALL be granted in the same cycle (zero-cycle grant latency).
REQ-015 Both requesting: arbitration per REQ-022/REQ-023.
REQ-016 Neither requesting: mem_en=0, mem_we=0, mem_addr and mem_wdata hold last values.
REQ-017 Output busy-state: last_gnt register SHALL record which port won the most recent transfer; unchanged in idle cycles.

Reset
REQ-018 While RESET=0: i_gnt=d_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-019 The cycle after RESET is sampled 0: i_rvalid=d_rvalid=0, response owner=RSP_NONE, last_gnt=instruction.
REQ-020 A read transferred in the cycle RESET is sampled 0 SHALL be blocked (no transfer); a response pending when reset is sampled SHALL be dropped.
REQ-021 First cycle after RESET returns to 1 SHALL arbitrate normally.

Configuration
REQ-022 Macro MEM_ARBITER_RR_EN defined: contention SHALL be resolved round-robin -- grant the port not equal to last_gnt (data wins first after reset).
REQ-023 Macro undefined: contention SHALL be resolved by fixed priority, data port always wins; last_gnt still maintained.

Verification
REQ-024 i_req=1, i_addr=0x0000_0008, mem contains 0x0000_0033 at word 2 -> i_gnt=1 same cycle, mem_addr=2; next cycle i_rvalid=1, i_rdata=0x0000_0033.
REQ-025 d_req=1, d_we=1, d_wmask=4'b0011, d_addr=0x0000_0404, d_wdata=0xDEAD_BEEF -> d_gnt=1, mem_addr=1 (wrap), mem_we=4'b0011; no d_rvalid; later read of word 1 returns low half 0xBEEF.
REQ-026 i_req=d_req=1 held 4 cycles -> without macro: d_gnt=1 all 4 cycles, i_gnt=0; with MEM_ARBITER_RR_EN: grants D,I,D,I.
REQ-027 Alternating I-read, D-read every cycle for 6 cycles -> mem_en=1 each cycle; i_rvalid/d_rvalid alternate one cycle later, each rdata matches its own address.
REQ-028 I-read granted, RESET=0 sampled next edge -> i_rvalid=0 following cycle, all gnt=0 during reset, first post-reset contention grants data.
